fifo_flex: RTL and testbench

Parametrised synchronous FIFO and successor to the fixed 16x8 FIFO.
- Depth need not be a power of two.
- Standard or first-word-fall-through (FWFT) read mode, chosen at elaboration.
- Occupancy count, separate almost-full and almost-empty levels, and synchronous flush.
- Sits between producer and consumer stages in one clock domain and replaces the older FIFO wherever level-based flow control or zero-latency reads are needed.

---
 rtl/fifo_flex_pkg.sv | 15 +
 rtl/fifo_flex_ram.sv | 25 ++
 rtl/fifo_flex.sv | 137 +++++++++++++
 tb/tb_fifo_flex.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flex_pkg.sv
// Shared constants and width helpers for the flexible FIFO.
package fifo_flex_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    function automatic int clog2_depth(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_flex_ram.sv
// Simple dual-port storage: synchronous write, combinational read; no flow control of its own.
module fifo_flex_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AW         = 3
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_flex.sv
// Parametrised sync FIFO, any depth; standard read 1-cycle latency or FWFT zero latency.
// Writes dropped (overflow pulse) when full without a same-cycle pop; empty reads pulse underflow.
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = FWFT_OFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = clog2_depth(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_flex: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_flex: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q;
    logic          wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0] ram_rd_dat;

    // A pop in the same cycle frees the slot a write into a full FIFO needs.
    assign rd_ok = rd_en && !empty_q;
    assign wr_ok = wr_en && (!full_q || rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_FULL);
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= AF_CNT);
            aempty_q <= (count_d <= AE_CNT);
            ovf_q    <= wr_en && full_q && !rd_ok;
            unf_q    <= rd_en && empty_q;
        end
    end

    fifo_flex_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk_i     (clk),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_dat)
    );

    if (FWFT == FWFT_ON) begin : g_fwft
        // Head is presented directly; forced to zero while empty so reset shows data_out = 0.
        assign data_out = empty_q ? '0 : ram_rd_dat;
        assign rd_valid = !empty_q;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  vld_q;
        always_ff @(posedge clk) begin
            if (reset || flush) begin
                dout_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                vld_q <= rd_ok;
                if (rd_ok) begin
                    dout_q <= ram_rd_dat;
                end
            end
        end
        assign data_out = dout_q;
        assign rd_valid = vld_q;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_flex.sv
// Directed bench: three fifo_flex instances (depth 8 std, depth 5 std, depth 8 FWFT) on shared inputs.
module tb_fifo_flex;

    logic        clk = 1'b0;
    logic        reset = 1'b1, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [15:0] data_in = '0;

    logic [15:0] d8, d5, df;
    logic        v8, v5, vf, f8, f5, ff, e8, e5, ef;
    logic        af8, af5, aff, ae8, ae5, aef;
    logic        o8, o5, of_, u8, u5, uf;
    logic [3:0]  c8, cf;
    logic [2:0]  c5;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_flex #(.DATA_WIDTH(16), .DEPTH(8), .AF_LEVEL(5), .AE_LEVEL(2), .FWFT(0)) dut8 (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(d8), .rd_valid(v8), .full(f8), .empty(e8), .almost_full(af8), .almost_empty(ae8),
        .count(c8), .overflow(o8), .underflow(u8));

    fifo_flex #(.DATA_WIDTH(16), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2), .FWFT(0)) dut5 (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(d5), .rd_valid(v5), .full(f5), .empty(e5), .almost_full(af5), .almost_empty(ae5),
        .count(c5), .overflow(o5), .underflow(u5));

    fifo_flex #(.DATA_WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dutf (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(df), .rd_valid(vf), .full(ff), .empty(ef), .almost_full(aff), .almost_empty(aef),
        .count(cf), .overflow(of_), .underflow(uf));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [15:0] d);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 16'h0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset and idle
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_empty", e8, 1);
            chk("rst_aempty", ae8, 1);
            chk("rst_full", f8, 0);
            chk("rst_afull", af8, 0);
            chk("rst_count", c8, 0);
            chk("rst_dout", d8, 0);
            chk("rst_valid", v8, 0);
            chk("rst_ovf", o8, 0);
            chk("rst_unf", u8, 0);
        end
        chk("rst_fwft_dout", df, 0);
        chk("rst_fwft_valid", vf, 0);

        // Fill depth-8 FIFO with 2..9, almost_full at 5, full at 8
        for (int i = 2; i <= 9; i++) begin
            drive(1'b1, 1'b0, 16'(i));
            tick();
            chk("fill_count", c8, i - 1);
            chk("fill_afull", af8, (i - 1) >= 5);
            chk("fill_full", f8, (i - 1) == 8);
            chk("fill_aempty", ae8, (i - 1) <= 2);
            chk("fill_ovf", o8, 0);
        end
        drive(1'b1, 1'b0, 16'h16);
        tick();
        chk("ovf_pulse", o8, 1);
        chk("ovf_count", c8, 8);
        chk("ovf_full", f8, 1);
        drive(1'b0, 1'b0, 16'h0);
        tick();
        chk("ovf_clear", o8, 0);
        chk("ovf_count2", c8, 8);

        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 16'h0);
            tick();
            chk("drain_data", d8, 2 + k);
            chk("drain_valid", v8, 1);
            chk("drain_count", c8, 7 - k);
        end
        chk("drain_empty", e8, 1);
        tick();
        chk("unf_pulse", u8, 1);
        chk("unf_valid", v8, 0);
        chk("unf_hold", d8, 9);
        drive(1'b0, 1'b0, 16'h0);
        tick();
        chk("unf_clear", u8, 0);

        // Simultaneous read and write while full
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 16'h20 + 16'(i));
            tick();
        end
        chk("rw_prefull", f8, 1);
        drive(1'b1, 1'b1, 16'h30);
        tick();
        chk("rw_count", c8, 8);
        chk("rw_full", f8, 1);
        chk("rw_ovf", o8, 0);
        chk("rw_data", d8, 16'h20);
        for (int k = 1; k < 8; k++) begin
            drive(1'b0, 1'b1, 16'h0);
            tick();
            chk("rw_drain", d8, 16'h20 + k);
        end
        tick();
        chk("rw_newword", d8, 16'h30);
        chk("rw_empty", e8, 1);
        drive(1'b0, 1'b0, 16'h0);

        // Non-power-of-two wrap, depth 5
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'h40 + 16'(i));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 16'h0);
            tick();
            chk("wrap_rd1", d5, 16'h40 + i);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 16'h50 + 16'(i));
            tick();
            chk("wrap_count", c5, i + 1);
        end
        chk("wrap_full", f5, 1);
        drive(1'b1, 1'b0, 16'h5F);
        tick();
        chk("wrap_count_max", c5, 5);
        chk("wrap_ovf", o5, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 16'h0);
            tick();
            chk("wrap_rd2", d5, 16'h50 + i);
        end
        chk("wrap_empty", e5, 1);
        drive(1'b0, 1'b0, 16'h0);

        // FWFT first word and read-at-empty with write
        do_reset();
        drive(1'b1, 1'b0, 16'h11);
        tick();
        drive(1'b0, 1'b0, 16'h0);
        chk("fwft_first", df, 16'h11);
        chk("fwft_valid", vf, 1);
        tick();
        chk("fwft_hold", df, 16'h11);
        chk("fwft_count", cf, 1);
        drive(1'b0, 1'b1, 16'h0);
        tick();
        chk("fwft_pop_empty", ef, 1);
        chk("fwft_pop_valid", vf, 0);
        drive(1'b1, 1'b1, 16'h12);
        tick();
        chk("fwft_unf", uf, 1);
        chk("fwft_unf_count", cf, 1);
        chk("fwft_unf_head", df, 16'h12);
        drive(1'b1, 1'b0, 16'h13);
        tick();
        chk("fwft_unf_clear", uf, 0);
        drive(1'b0, 1'b1, 16'h0);
        tick();
        chk("fwft_adv", df, 16'h13);
        chk("fwft_adv_count", cf, 1);
        drive(1'b0, 1'b0, 16'h0);

        // Flush with 4 stored, then post-flush traffic
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 16'h60 + 16'(i));
            tick();
        end
        drive(1'b0, 1'b1, 16'h0);
        tick();
        chk("pre_flush_rd", d8, 16'h60);
        drive(1'b0, 1'b0, 16'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_count", c8, 0);
        chk("flush_empty", e8, 1);
        chk("flush_dout", d8, 0);
        chk("flush_valid", v8, 0);
        drive(1'b1, 1'b0, 16'h70);
        tick();
        drive(1'b1, 1'b0, 16'h71);
        tick();
        drive(1'b0, 1'b1, 16'h0);
        tick();
        chk("post_flush_rd0", d8, 16'h70);
        tick();
        chk("post_flush_rd1", d8, 16'h71);
        tick();
        chk("post_flush_unf", u8, 1);
        chk("post_flush_hold", d8, 16'h71);

        // Reset wins over a simultaneous write
        drive(1'b1, 1'b0, 16'h80);
        tick();
        drive(1'b1, 1'b0, 16'h99);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 16'h0);
        chk("rst_wr_count", c8, 0);
        chk("rst_wr_empty", e8, 1);
        tick();
        chk("rst_wr_count2", c8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
